// File: rtl/raster_engine_param.sv
`default_nettype none
// ============================================================================
// raster_engine_param : CLEAR/POINT/RECT/LINE rasterizer with continuous scan-out
// Macro RASTER_CLIP_EN : clip RECT pixels past the right/bottom edge (default wraps)
// Rev 1.0
// ============================================================================
module raster_engine_param #(
   parameter int  GRID_W  = 8,
   parameter int  GRID_H  = 8,
   parameter int  COLOR_W = 4,
   localparam int XW      = $clog2(GRID_W),
   localparam int YW      = $clog2(GRID_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [XW-1:0]      cmd_x0,
   input  logic [YW-1:0]      cmd_y0,
   input  logic [XW-1:0]      cmd_x1,
   input  logic [YW-1:0]      cmd_y1,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic               busy,
   output logic [COLOR_W-1:0] pixel_data,
   output logic               frame_sync
);

   localparam int MW   = (XW > YW) ? XW : YW;
   localparam int EW   = MW + 2;
   localparam int AW   = XW + YW;
   localparam int NPIX = GRID_W * GRID_H;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POINT = 2'd1,
      S_RECT  = 2'd2,
      S_LINE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [COLOR_W-1:0] fb [NPIX];
   logic [AW-1:0]      scan;

   logic [COLOR_W-1:0] color;
   logic [XW-1:0]      base_x, rect_w, ox;
   logic [YW-1:0]      base_y, rect_h, oy;

   logic [XW-1:0]      lx;
   logic [YW-1:0]      ly;
   logic               sx, sy, steep;
   logic [MW-1:0]      lmin, lmaj, cnt;
   logic [EW-1:0]      err;

   logic               accept, clear_fire;
   logic               wr_en;
   logic [XW-1:0]      wr_x, rect_x;
   logic [YW-1:0]      wr_y, rect_y;
   logic               rect_in, rect_last;
   logic [AW-1:0]      wr_idx;

   logic [XW-1:0]      dx_abs;
   logic [YW-1:0]      dy_abs;
   logic [MW-1:0]      dx_m, dy_m, maj_c, min_c;
   logic               steep_c;
   logic [EW-1:0]      err_init, err_step_hi, err_step_lo;

   assign cmd_ready  = (state == S_IDLE);
   assign busy       = ~cmd_ready;
   assign accept     = cmd_valid & cmd_ready;
   assign clear_fire = accept & (cmd_op == 2'b00);

   // Line setup: octant reduced to |major|/|minor| with direction signs
   assign dx_abs   = (cmd_x1 >= cmd_x0) ? cmd_x1 - cmd_x0 : cmd_x0 - cmd_x1;
   assign dy_abs   = (cmd_y1 >= cmd_y0) ? cmd_y1 - cmd_y0 : cmd_y0 - cmd_y1;
   assign dx_m     = MW'(dx_abs);
   assign dy_m     = MW'(dy_abs);
   assign steep_c  = dy_m > dx_m;
   assign maj_c    = steep_c ? dy_m : dx_m;
   assign min_c    = steep_c ? dx_m : dy_m;
   assign err_init = {1'b0, min_c, 1'b0} - {2'b00, maj_c};

   assign err_step_hi = {1'b0, lmin, 1'b0} - {1'b0, lmaj, 1'b0};
   assign err_step_lo = {1'b0, lmin, 1'b0};

`ifdef RASTER_CLIP_EN
   logic [XW:0] rect_xs;
   logic [YW:0] rect_ys;
   assign rect_xs = {1'b0, base_x} + {1'b0, ox};
   assign rect_ys = {1'b0, base_y} + {1'b0, oy};
   assign rect_x  = rect_xs[XW-1:0];
   assign rect_y  = rect_ys[YW-1:0];
   assign rect_in = ~rect_xs[XW] & ~rect_ys[YW];
`else
   assign rect_x  = base_x + ox;
   assign rect_y  = base_y + oy;
   assign rect_in = 1'b1;
`endif

   assign rect_last = (ox == rect_w) && (oy == rect_h);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_x      = '0;
      wr_y      = '0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  2'b01:   state_nxt = S_POINT;
                  2'b10:   state_nxt = S_RECT;
                  2'b11:   state_nxt = S_LINE;
                  default: state_nxt = S_IDLE;
               endcase
            end
         end
         S_POINT: begin
            wr_en     = 1'b1;
            wr_x      = base_x;
            wr_y      = base_y;
            state_nxt = S_IDLE;
         end
         S_RECT: begin
            // Clipped pixels still burn their cycle
            wr_en = rect_in;
            wr_x  = rect_x;
            wr_y  = rect_y;
            if (rect_last) state_nxt = S_IDLE;
         end
         S_LINE: begin
            wr_en = 1'b1;
            wr_x  = lx;
            wr_y  = ly;
            if (cnt == '0) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color  <= '0;
         base_x <= '0;
         base_y <= '0;
         rect_w <= '0;
         rect_h <= '0;
         ox     <= '0;
         oy     <= '0;
         lx     <= '0;
         ly     <= '0;
         sx     <= 1'b0;
         sy     <= 1'b0;
         steep  <= 1'b0;
         lmin   <= '0;
         lmaj   <= '0;
         cnt    <= '0;
         err    <= '0;
      end else if (accept) begin
         color  <= cmd_color;
         base_x <= cmd_x0;
         base_y <= cmd_y0;
         rect_w <= cmd_x1;
         rect_h <= cmd_y1;
         ox     <= '0;
         oy     <= '0;
         lx     <= cmd_x0;
         ly     <= cmd_y0;
         sx     <= cmd_x1 < cmd_x0;
         sy     <= cmd_y1 < cmd_y0;
         steep  <= steep_c;
         lmin   <= min_c;
         lmaj   <= maj_c;
         cnt    <= maj_c;
         err    <= err_init;
      end else begin
         if (state == S_RECT) begin
            if (ox == rect_w) begin
               ox <= '0;
               oy <= oy + YW'(1);
            end else begin
               ox <= ox + XW'(1);
            end
         end
         if (state == S_LINE && cnt != '0) begin
            cnt <= cnt - MW'(1);
            // Non-negative error (including exactly zero) steps the minor axis
            if (steep) begin
               ly <= sy ? ly - YW'(1) : ly + YW'(1);
               if (!err[EW-1]) lx <= sx ? lx - XW'(1) : lx + XW'(1);
            end else begin
               lx <= sx ? lx - XW'(1) : lx + XW'(1);
               if (!err[EW-1]) ly <= sy ? ly - YW'(1) : ly + YW'(1);
            end
            err <= err + (err[EW-1] ? err_step_lo : err_step_hi);
         end
      end
   end

   assign wr_idx = {wr_y, wr_x};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPIX; i++) fb[i] <= '0;
      end else if (clear_fire) begin
         for (int i = 0; i < NPIX; i++) fb[i] <= cmd_color;
      end else if (wr_en) begin
         fb[wr_idx] <= color;
      end
   end

   // Scan-out reads the pre-edge framebuffer, so a same-edge write is not visible yet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan       <= '0;
         pixel_data <= '0;
         frame_sync <= 1'b0;
      end else begin
         pixel_data <= fb[scan];
         frame_sync <= (scan == '0);
         scan       <= scan + AW'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_raster_engine_param.sv
`default_nettype none
// tb_raster_engine_param : directed and randomized checks of raster_engine_param
// against a pixel-level model built from geometric rules.
module tb_raster_engine_param;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int CW   = 4;
   localparam int XW   = 3;
   localparam int YW   = 3;
   localparam int NPIX = W * H;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op    = 2'b00;
   logic [XW-1:0] cmd_x0    = '0;
   logic [YW-1:0] cmd_y0    = '0;
   logic [XW-1:0] cmd_x1    = '0;
   logic [YW-1:0] cmd_y1    = '0;
   logic [CW-1:0] cmd_color = '0;
   logic          cmd_ready;
   logic          busy;
   logic [CW-1:0] pixel_data;
   logic          frame_sync;

   int            checks = 0;
   int            errors = 0;

   logic [CW-1:0] mfb [NPIX];
   logic [CW-1:0] got [NPIX];

   always #5 clk = ~clk;

   raster_engine_param #(
      .GRID_W  (W),
      .GRID_H  (H),
      .COLOR_W (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_x0     (cmd_x0),
      .cmd_y0     (cmd_y0),
      .cmd_x1     (cmd_x1),
      .cmd_y1     (cmd_y1),
      .cmd_color  (cmd_color),
      .busy       (busy),
      .pixel_data (pixel_data),
      .frame_sync (frame_sync)
   );

   // ---------------- reference model ----------------
   task automatic m_plot(input int x, input int y, input logic [CW-1:0] c);
      mfb[(y % H) * W + (x % W)] = c;
   endtask

   task automatic m_clear(input logic [CW-1:0] c);
      for (int i = 0; i < NPIX; i++) mfb[i] = c;
   endtask

   task automatic m_rect(input int x0, input int y0, input int w, input int h,
                         input logic [CW-1:0] c);
      for (int j = 0; j <= h; j++)
         for (int i = 0; i <= w; i++) begin
`ifdef RASTER_CLIP_EN
            if (x0 + i < W && y0 + j < H) m_plot(x0 + i, y0 + j, c);
`else
            m_plot(x0 + i, y0 + j, c);
`endif
         end
   endtask

   // Minor offset = major step * slope, rounded half up toward the next minor pixel
   task automatic m_line(input int x0, input int y0, input int x1, input int y1,
                         input logic [CW-1:0] c);
      int adx, ady, sx, sy, m;
      adx = (x1 >= x0) ? x1 - x0 : x0 - x1;
      ady = (y1 >= y0) ? y1 - y0 : y0 - y1;
      sx  = (x1 >= x0) ? 1 : -1;
      sy  = (y1 >= y0) ? 1 : -1;
      if (adx >= ady) begin
         for (int i = 0; i <= adx; i++) begin
            m = (adx == 0) ? 0 : (2 * i * ady + adx) / (2 * adx);
            m_plot(x0 + sx * i, y0 + sy * m, c);
         end
      end else begin
         for (int i = 0; i <= ady; i++) begin
            m = (2 * i * adx + ady) / (2 * ady);
            m_plot(x0 + sx * m, y0 + sy * i, c);
         end
      end
   endtask

   task automatic m_apply(input int op, input int x0, input int y0, input int x1,
                          input int y1, input logic [CW-1:0] c, output int exp_busy);
      int adx, ady;
      adx = (x1 >= x0) ? x1 - x0 : x0 - x1;
      ady = (y1 >= y0) ? y1 - y0 : y0 - y1;
      case (op)
         0: begin m_clear(c); exp_busy = 0; end
         1: begin m_plot(x0, y0, c); exp_busy = 1; end
         2: begin m_rect(x0, y0, x1, y1, c); exp_busy = (x1 + 1) * (y1 + 1); end
         default: begin
            m_line(x0, y0, x1, y1, c);
            exp_busy = ((adx > ady) ? adx : ady) + 1;
         end
      endcase
   endtask

   // ---------------- stimulus / capture helpers ----------------
   // Called at a negedge; returns at the negedge where busy is low again.
   task automatic do_cmd(input int op, input int x0, input int y0, input int x1,
                         input int y1, input logic [CW-1:0] c, output int nbusy);
      int guard;
      guard     = 0;
      cmd_op    = 2'(op);
      cmd_x0    = XW'(x0);
      cmd_y0    = YW'(y0);
      cmd_x1    = XW'(x1);
      cmd_y1    = YW'(y1);
      cmd_color = c;
      cmd_valid = 1'b1;
      while (!cmd_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      nbusy = 0;
      while (busy && nbusy < 5000) begin
         nbusy++;
         @(negedge clk);
      end
      if (guard >= 1000 || nbusy >= 5000) nbusy = -1;
   endtask

   // Captures one full frame into got[]; bad = mismatching pixels vs mfb, -1 on timeout.
   task automatic capture_frame(output int bad, output int first);
      int guard;
      guard = 0;
      bad   = 0;
      first = -1;
      while (frame_sync !== 1'b1 && guard < 2 * NPIX) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2 * NPIX) begin
         bad = -1;
      end else begin
         got[0] = pixel_data;
         for (int p = 1; p < NPIX; p++) begin
            @(negedge clk);
            got[p] = pixel_data;
            if (frame_sync !== 1'b0) bad++;
         end
         for (int p = 0; p < NPIX; p++)
            if (got[p] !== mfb[p]) begin
               bad++;
               if (first < 0) first = p;
            end
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      int sync_bad, pix_bad;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || pixel_data !== '0 || frame_sync !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b busy=%b pix=%h sync=%b, want 1 0 0 0",
                  cmd_ready, busy, pixel_data, frame_sync);
      end
      rst_n    = 1'b1;
      sync_bad = 0;
      pix_bad  = 0;
      for (int i = 1; i <= 65; i++) begin
         @(negedge clk);
         if (frame_sync !== ((i == 1) || (i == 65))) sync_bad++;
         if (pixel_data !== '0) pix_bad++;
      end
      checks++;
      if (sync_bad != 0) begin
         errors++;
         $display("FAIL reset_frame_sync: %0d wrong cycles, want sync only on cycles 1 and 65", sync_bad);
      end
      checks++;
      if (pix_bad != 0) begin
         errors++;
         $display("FAIL reset_pixels: %0d nonzero pixels, want 0", pix_bad);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", cmd_ready);
      end
      m_clear('0);
   endtask

   task automatic test_clear_point;
      int nb, eb, bad, first;
      do_cmd(0, 0, 0, 0, 0, 4'hA, nb);
      m_apply(0, 0, 0, 0, 0, 4'hA, eb);
      checks++;
      if (nb !== eb || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_busy: got busy=%0d ready=%b want %0d 1", nb, cmd_ready, eb);
      end
      do_cmd(1, 3, 5, 0, 0, 4'h3, nb);
      m_apply(1, 3, 5, 0, 0, 4'h3, eb);
      checks++;
      if (nb !== eb) begin
         errors++;
         $display("FAIL point_busy: got %0d want %0d", nb, eb);
      end
      capture_frame(bad, first);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL point_frame: %0d bad, first idx %0d", bad, first);
      end
      checks++;
      if (got[43] !== 4'h3) begin
         errors++;
         $display("FAIL point_pixel43: got %h want 3", got[43]);
      end
   endtask

   task automatic test_rect;
      int nb, eb, bad, first;
      do_cmd(0, 0, 0, 0, 0, 4'h0, nb);
      m_apply(0, 0, 0, 0, 0, 4'h0, eb);
      do_cmd(2, 1, 2, 2, 1, 4'h5, nb);
      m_apply(2, 1, 2, 2, 1, 4'h5, eb);
      checks++;
      if (nb !== 6) begin
         errors++;
         $display("FAIL rect_busy: got %0d want 6", nb);
      end
      capture_frame(bad, first);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL rect_frame: %0d bad, first idx %0d got %h want %h", bad, first,
                  (first >= 0) ? got[first] : 4'h0, (first >= 0) ? mfb[first] : 4'h0);
      end
   endtask

   task automatic test_line;
      int nb, eb, bad, first;
      int lines [3][4] = '{'{0, 0, 7, 3}, '{7, 3, 0, 0}, '{3, 7, 0, 0}};
      for (int k = 0; k < 3; k++) begin
         do_cmd(0, 0, 0, 0, 0, 4'h0, nb);
         m_apply(0, 0, 0, 0, 0, 4'h0, eb);
         do_cmd(3, lines[k][0], lines[k][1], lines[k][2], lines[k][3], 4'hF, nb);
         m_apply(3, lines[k][0], lines[k][1], lines[k][2], lines[k][3], 4'hF, eb);
         checks++;
         if (nb !== 8) begin
            errors++;
            $display("FAIL line%0d_busy: got %0d want 8", k, nb);
         end
         capture_frame(bad, first);
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL line%0d_frame: %0d bad, first idx %0d", k, bad, first);
         end
      end
   endtask

   task automatic test_edge_rect;
      int nb, eb, bad, first;
      do_cmd(0, 0, 0, 0, 0, 4'h0, nb);
      m_apply(0, 0, 0, 0, 0, 4'h0, eb);
      do_cmd(2, 6, 6, 3, 3, 4'h9, nb);
      m_apply(2, 6, 6, 3, 3, 4'h9, eb);
      checks++;
      if (nb !== 16) begin
         errors++;
         $display("FAIL edge_rect_busy: got %0d want 16", nb);
      end
      capture_frame(bad, first);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL edge_rect_frame: %0d bad, first idx %0d", bad, first);
      end
   endtask

   task automatic test_reset_abort;
      int nb, bad, first;
      cmd_op = 2'b10; cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = 3'd3; cmd_y1 = 3'd3;
      cmd_color = 4'h7;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || pixel_data !== '0 || frame_sync !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: got ready=%b busy=%b pix=%h sync=%b want 1 0 0 0",
                  cmd_ready, busy, pixel_data, frame_sync);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_clear('0);
      capture_frame(bad, first);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL abort_frame: %0d bad, first idx %0d", bad, first);
      end
      nb = 0;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_back_to_back;
      int nb, eb, bad, first;
      cmd_op = 2'b10; cmd_x0 = 3'd0; cmd_y0 = 3'd0; cmd_x1 = 3'd1; cmd_y1 = 3'd1;
      cmd_color = 4'h6;
      cmd_valid = 1'b1;
      @(negedge clk);
      m_apply(2, 0, 0, 1, 1, 4'h6, eb);
      // Held request: a different command kept valid while the RECT is busy
      cmd_op = 2'b01; cmd_x0 = 3'd5; cmd_y0 = 3'd5; cmd_color = 4'hC;
      nb = 0;
      while (busy && nb < 100) begin
         nb++;
         @(negedge clk);
      end
      checks++;
      if (nb !== eb) begin
         errors++;
         $display("FAIL held_rect_busy: got %0d want %0d", nb, eb);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL held_accept: busy got %b want 1 after idle", busy);
      end
      m_apply(1, 5, 5, 0, 0, 4'hC, eb);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL held_point_done: busy got %b want 0", busy);
      end
      capture_frame(bad, first);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL held_frame: %0d bad, first idx %0d", bad, first);
      end
   endtask

   task automatic test_random;
      int nb, eb, bad, first, op, x0, y0, x1, y1;
      logic [CW-1:0] c;
      for (int n = 0; n < 24; n++) begin
         op = (n == 0) ? 0 : (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)));
         x0 = $urandom_range(0, W - 1);
         y0 = $urandom_range(0, H - 1);
         x1 = $urandom_range(0, W - 1);
         y1 = $urandom_range(0, H - 1);
         c  = CW'($urandom);
         do_cmd(op, x0, y0, x1, y1, c, nb);
         m_apply(op, x0, y0, x1, y1, c, eb);
         checks++;
         if (nb !== eb) begin
            errors++;
            $display("FAIL rand%0d_busy: op=%0d (%0d,%0d,%0d,%0d) got %0d want %0d",
                     n, op, x0, y0, x1, y1, nb, eb);
         end
         capture_frame(bad, first);
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL rand%0d_frame: op=%0d (%0d,%0d,%0d,%0d) %0d bad, first idx %0d",
                     n, op, x0, y0, x1, y1, bad, first);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_point();
      test_rect();
      test_line();
      test_edge_rect();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
